// File: rtl/voice_mixer_if.sv
// voice_mixer_if: voice inputs and mixed PWM sample outputs of the voice mixer.
//   master: drives voice_on/voice_vel/voice_sample, observes the mixer outputs.
//   slave : the mixer; consumes voice data, drives pwm_data, pwm_data_ready,
//           clip, active_count, busy.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 8
) ();
    logic [NUM_VOICES-1:0]                voice_on;
    logic [NUM_VOICES-1:0][7:0]           voice_vel;
    logic [NUM_VOICES-1:0][7:0]           voice_sample;
    logic [7:0]                           pwm_data;
    logic                                 pwm_data_ready;
    logic                                 clip;
    logic [$clog2(NUM_VOICES+1)-1:0]      active_count;
    logic                                 busy;

    modport master (
        output voice_on, voice_vel, voice_sample,
        input  pwm_data, pwm_data_ready, clip, active_count, busy
    );

    modport slave (
        input  voice_on, voice_vel, voice_sample,
        output pwm_data, pwm_data_ready, clip, active_count, busy
    );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: N-voice mixer with per-voice linear envelopes, one shared MAC and
// a saturating offset-binary 8-bit output sample once per SAMPLE_PERIOD.
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : voice_mixer_if.slave (voice on/velocity/sample in; pwm_data,
//            pwm_data_ready, clip, active_count, busy out)
module voice_mixer #(
    parameter int NUM_VOICES    = 8,
    parameter int SAMPLE_PERIOD = 4536,
    parameter int ATTACK_STEP   = 16,
    parameter int RELEASE_STEP  = 8,
    parameter int OUT_SHIFT     = 2
) (
    input logic            clk_in,
    input logic            rst_in,
    voice_mixer_if.slave   bus
);
    localparam int CW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AW = 18 + CW;
    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int NW = $clog2(NUM_VOICES + 1);
    localparam logic signed [AW-1:0] MID  = 128;
    localparam logic signed [AW-1:0] MAXV = 255;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                      state, state_nxt;
    logic [TW-1:0]               cnt;
    logic                        tick;
    logic [NUM_VOICES-1:0][7:0]  env, env_nxt, tgt, smp;
    logic [NW-1:0]               active_nxt;
    logic [CW-1:0]               idx;
    logic signed [AW-1:0]        acc, res;
    logic signed [8:0]           centred;
    logic signed [17:0]          prod;
    logic                        lo, hi;
    logic [7:0]                  r_sat;
    logic                        load, acc_en, finish;

    // free-running sample-rate counter, independent of the FSM
    assign tick = (cnt == TW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + TW'(1);
    end

    // envelope step toward target, clamped so it never overshoots or wraps
    always_comb begin
        tgt        = '0;
        env_nxt    = '0;
        active_nxt = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            tgt[i]     = bus.voice_on[i] ? bus.voice_vel[i] : 8'd0;
            env_nxt[i] = (env[i] < tgt[i])
                       ? ((tgt[i] - env[i] > 8'(ATTACK_STEP))  ? env[i] + 8'(ATTACK_STEP)  : tgt[i])
                       : ((env[i] - tgt[i] > 8'(RELEASE_STEP)) ? env[i] - 8'(RELEASE_STEP) : tgt[i]);
            active_nxt = active_nxt + NW'(env_nxt[i] != 8'd0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)  ? (tick ? ACCUM : IDLE)
                  : (state == ACCUM) ? ((idx == CW'(NUM_VOICES - 1)) ? DONE : ACCUM)
                  : IDLE;
    end

    always_comb begin
        load     = (state == IDLE) && tick;
        acc_en   = (state == ACCUM);
        finish   = (state == DONE);
        bus.busy = (state != IDLE);
    end

    // one voice per cycle through the shared multiplier; the result stage
    // normalises by 128, applies OUT_SHIFT, re-centres and saturates
    always_comb begin
        centred = $signed({1'b0, smp[idx]}) - 9'sd128;
        prod    = centred * $signed({1'b0, env[idx]});
        res     = (acc >>> (7 + OUT_SHIFT)) + MID;
        lo      = res[AW-1];
        hi      = !lo && (res > MAXV);
        r_sat   = lo ? 8'd0 : hi ? 8'd255 : res[7:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            env                <= '0;
            smp                <= '0;
            acc                <= '0;
            idx                <= '0;
            bus.pwm_data       <= 8'd128;
            bus.pwm_data_ready <= 1'b0;
            bus.clip           <= 1'b0;
            bus.active_count   <= '0;
        end else begin
            bus.pwm_data_ready <= finish;
            bus.clip           <= finish && (lo || hi);
            if (load) begin
                env              <= env_nxt;
                smp              <= bus.voice_sample;
                bus.active_count <= active_nxt;
                acc              <= '0;
                idx              <= '0;
            end
            if (acc_en) begin
                acc <= acc + AW'(prod);
                idx <= idx + CW'(1);
            end
            if (finish) bus.pwm_data <= r_sat;
        end
    end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed checks of voice_mixer (reset, latency, attack,
// release, saturation/clip, input latching, mid-sample reset abort).
module tb_voice_mixer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc, data, clp, act;

    always #5 clk = ~clk;

    voice_mixer_if #(.NUM_VOICES(8)) va ();
    voice_mixer_if #(.NUM_VOICES(8)) vb ();

    voice_mixer #(.NUM_VOICES(8), .SAMPLE_PERIOD(16), .ATTACK_STEP(255),
                  .RELEASE_STEP(40), .OUT_SHIFT(2))
        dut_a (.clk_in(clk), .rst_in(rst), .bus(va.slave));

    voice_mixer #(.NUM_VOICES(8), .SAMPLE_PERIOD(16), .ATTACK_STEP(32),
                  .RELEASE_STEP(40), .OUT_SHIFT(2))
        dut_b (.clk_in(clk), .rst_in(rst), .bus(vb.slave));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] on, input logic [7:0] vel,
                         input logic [7:0] smp);
        if (sel) begin
            vb.voice_on = on; vb.voice_vel = {8{vel}}; vb.voice_sample = {8{smp}};
        end else begin
            va.voice_on = on; va.voice_vel = {8{vel}}; va.voice_sample = {8{smp}};
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk) rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_ready(input bit sel, output int c, output int d,
                              output int cl, output int ac);
        bit seen = 1'b0;
        c = 0; d = -1; cl = -1; ac = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            c++;
            if (sel ? vb.pwm_data_ready : va.pwm_data_ready) begin
                seen = 1'b1;
                d  = sel ? int'(vb.pwm_data)     : int'(va.pwm_data);
                cl = sel ? int'(vb.clip)         : int'(va.clip);
                ac = sel ? int'(vb.active_count) : int'(va.active_count);
            end
        end
        if (!seen) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            seen = va.busy;
        end
        chk("busy_seen", int'(seen), 1);
    endtask

    initial begin
        int ramp [4] = '{143, 151, 152, 152};
        int rel_d[4] = '{142, 132, 128, 128};
        int rel_a[4] = '{1, 1, 0, 0};
        drive(0, 8'h00, 8'd0, 8'd128);
        drive(1, 8'h00, 8'd0, 8'd128);

        // reset state
        do_reset(3);
        chk("t1_pwm", va.pwm_data, 128);
        chk("t1_ready", va.pwm_data_ready, 0);
        chk("t1_clip", va.clip, 0);
        chk("t1_active", va.active_count, 0);
        chk("t1_busy", va.busy, 0);
        chk("t1_pwm_b", vb.pwm_data, 128);

        // single voice, latency and pulse width
        drive(0, 8'h01, 8'd127, 8'd255);
        do_reset(3);
        wait_ready(0, cyc, data, clp, act);
        chk("t2_latency", cyc, 25);
        chk("t2_data", data, 159);
        chk("t2_clip", clp, 0);
        chk("t2_active", act, 1);
        @(posedge clk); #1;
        chk("t2_pulse_width", va.pwm_data_ready, 0);
        wait_ready(0, cyc, data, clp, act);
        chk("t2_period", cyc, 15);
        chk("t2_data2", data, 159);

        // attack ramp 32,64,96,100,100
        drive(1, 8'h01, 8'd100, 8'd255);
        do_reset(3);
        wait_ready(1, cyc, data, clp, act);
        chk("t3_data0", data, 135);
        for (int i = 0; i < 4; i++) begin
            wait_ready(1, cyc, data, clp, act);
            chk("t3_period", cyc, 16);
            chk("t3_data", data, ramp[i]);
            chk("t3_active", act, 1);
        end

        // saturation both ways, centre, and mid-ACCUM input change
        drive(0, 8'hFF, 8'd255, 8'd255);
        do_reset(3);
        wait_ready(0, cyc, data, clp, act);
        chk("t4_hi_data", data, 255);
        chk("t4_hi_clip", clp, 1);
        chk("t4_active", act, 8);
        drive(0, 8'hFF, 8'd255, 8'd0);
        wait_ready(0, cyc, data, clp, act);
        chk("t4_lo_data", data, 0);
        chk("t4_lo_clip", clp, 1);
        drive(0, 8'hFF, 8'd255, 8'd128);
        wait_ready(0, cyc, data, clp, act);
        chk("t4_mid_data", data, 128);
        chk("t4_mid_clip", clp, 0);
        wait_busy();
        drive(0, 8'hFF, 8'd255, 8'd255);
        wait_ready(0, cyc, data, clp, act);
        chk("t4_latched_lat", cyc, 9);
        chk("t4_latched_data", data, 128);
        chk("t4_latched_clip", clp, 0);
        wait_ready(0, cyc, data, clp, act);
        chk("t4_after_data", data, 255);
        chk("t4_after_clip", clp, 1);

        // release 100 -> 60,20,0
        drive(0, 8'h01, 8'd100, 8'd255);
        do_reset(3);
        wait_ready(0, cyc, data, clp, act);
        chk("t5_data0", data, 152);
        chk("t5_active0", act, 1);
        drive(0, 8'h00, 8'd100, 8'd255);
        for (int i = 0; i < 4; i++) begin
            wait_ready(0, cyc, data, clp, act);
            chk("t5_data", data, rel_d[i]);
            chk("t5_active", act, rel_a[i]);
            chk("t5_clip", clp, 0);
        end

        // reset two cycles into ACCUM aborts the sample
        drive(0, 8'h01, 8'd100, 8'd255);
        do_reset(3);
        wait_ready(0, cyc, data, clp, act);
        chk("t6_data0", data, 152);
        wait_busy();
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        drive(0, 8'h00, 8'd100, 8'd255);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("t6_pwm_rst", va.pwm_data, 128);
        chk("t6_busy_rst", va.busy, 0);
        chk("t6_ready_rst", va.pwm_data_ready, 0);
        chk("t6_active_rst", va.active_count, 0);
        wait_ready(0, cyc, data, clp, act);
        chk("t6_latency", cyc, 25);
        chk("t6_data", data, 128);
        chk("t6_active", act, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
